// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and operand-sign helpers for muldiv_unit
package muldiv_pkg;
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction
  function automatic logic a_signed(input logic [2:0] op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction
  function automatic logic b_signed(input logic [2:0] op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add or restoring-divide iteration on the {hi,lo} accumulator (divide only with MULDIV_DIV_EN)
module muldiv_step #(
  parameter int XLEN = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic              div,
`endif
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] nxt
);
  logic [XLEN:0] sum;
  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
`ifdef MULDIV_DIV_EN
  logic [XLEN:0] diff;
  assign diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  assign nxt = div ? (diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                   : {sum, acc[XLEN-1:1]};
`else
  assign nxt = {sum, acc[XLEN-1:1]};
`endif
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed-latency iterative RV32M multiply/divide; divide datapath only with MULDIV_DIV_EN
module muldiv_unit import muldiv_pkg::*; #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  state_t state;
  logic [2:0] op_r;
  logic [XLEN-1:0] a_r, b_r, opnd, abs_a, abs_b, mul_res, fix_res;
  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic [CNT_W-1:0] cnt;
  logic neg_q, sa, sb, fix_ill;
  assign sa = a_signed(op_r) && a_r[XLEN-1];
  assign sb = b_signed(op_r) && b_r[XLEN-1];
  assign abs_a = sa ? -a_r : a_r;
  assign abs_b = sb ? -b_r : b_r;
  assign busy = state inside {PREP, RUN, FIX};
  assign done = state == DONE;
  assign prod = neg_q ? -acc : acc;
  assign mul_res = op_r inside {MD_MULH, MD_MULHSU, MD_MULHU} ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`ifdef MULDIV_DIV_EN
  logic neg_r, dz, ovf;
  logic [XLEN-1:0] quo, rem;
  assign dz = b_r == '0;
  assign ovf = op_r inside {MD_DIV, MD_REM} && a_r == {1'b1, {(XLEN-1){1'b0}}} && &b_r;
  assign quo = dz ? '1 : ovf ? a_r : neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem = dz ? a_r : ovf ? '0 : neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign fix_res = is_div(op_r) ? (op_r inside {MD_DIV, MD_DIVU} ? quo : rem) : mul_res;
  assign fix_ill = 1'b0;
`else
  assign fix_res = is_div(op_r) ? '0 : mul_res;
  assign fix_ill = is_div(op_r);
`endif
  muldiv_step #(.XLEN(XLEN)) u_step (
`ifdef MULDIV_DIV_EN
    .div(is_div(op_r)),
`endif
    .acc(acc),
    .opnd(opnd),
    .nxt(acc_nx)
  );
  // Sequencer: accept, prepare magnitudes, iterate XLEN times, fix signs, pulse done
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      opnd <= '0;
      acc <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r <= 1'b0;
`endif
      result <= '0;
      illegal <= 1'b0;
    end else if (flush && busy) state <= IDLE;
    else
      case (state)
        PREP: begin
          acc <= {{XLEN{1'b0}}, is_div(op_r) ? abs_a : abs_b};
          opnd <= is_div(op_r) ? abs_b : abs_a;
          cnt <= '0;
          neg_q <= sa ^ sb;
`ifdef MULDIV_DIV_EN
          neg_r <= sa;
`endif
          state <= RUN;
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          illegal <= fix_ill;
          state <= DONE;
        end
        default:
          if (start && !flush) begin
            op_r <= op;
            a_r <= a;
            b_r <= b;
            state <= PREP;
          end else state <= IDLE;
      endcase
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit (divide expectations follow MULDIV_DIV_EN)
module tb_muldiv_unit;
  import muldiv_pkg::*;
`ifdef MULDIV_DIV_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0, result;
  logic busy, done, illegal;
  int errors = 0, checks = 0, n, c;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1 start = 1'b0;
      cnt++;
    end while (!done && cnt < 100);
  endtask

  task automatic count_done(input int k, output int cnt);
    cnt = 0;
    repeat (k) begin
      @(posedge clk);
      #1 if (done) cnt++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input logic ei);
    int m;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    wait_done(m);
    chk({tag, "_lat"}, m, 35);
    chk({tag, "_res"}, result, er);
    chk({tag, "_ill"}, illegal, ei);
    @(posedge clk);
    #1 chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk) reset = 1'b0;

    @(negedge clk);
    op = MD_MUL; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mul_busy_early", busy, 1);
    wait_done(n);
    chk("mul_lat", n, 34);
    chk("mul_busy_done", busy, 0);
    chk("mul_res", result, 32'hFFFF_FFEB);
    chk("mul_ill", illegal, 0);
    @(posedge clk);
    #1 chk("mul_pulse", done, 0);

    run("mulh", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, DE ? 32'hFFFF_FFFD : 32'h0, !DE);
    run("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2, DE ? 32'hFFFF_FFFF : 32'h0, !DE);
    run("divu_z", MD_DIVU, 32'd5, 32'd0, DE ? 32'hFFFF_FFFF : 32'h0, !DE);
    run("remu_z", MD_REMU, 32'd5, 32'd0, DE ? 32'd5 : 32'h0, !DE);
    run("div_z", MD_DIV, 32'hFFFF_FFFB, 32'd0, DE ? 32'hFFFF_FFFF : 32'h0, !DE);
    run("rem_z", MD_REM, 32'hFFFF_FFFB, 32'd0, DE ? 32'hFFFF_FFFB : 32'h0, !DE);
    run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DE ? 32'h8000_0000 : 32'h0, !DE);
    run("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, !DE);
    run("div_10_3", MD_DIV, 32'd10, 32'd3, DE ? 32'd3 : 32'h0, !DE);
    run("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'd16, DE ? 32'h0FFF_FFFF : 32'h0, !DE);
    run("mul_10_3", MD_MUL, 32'd10, 32'd3, 32'd30, 1'b0);

    @(negedge clk);
    op = MD_MUL; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = MD_DIV; a = 32'd100; b = 32'd5; start = 1'b1;
    wait_done(n);
    chk("busy_start_lat", n, 30);
    chk("busy_start_res", result, 32'd42);
    chk("busy_start_ill", illegal, 0);

    start = 1'b1; op = MD_MUL; a = 32'd3; b = 32'd4;
    wait_done(n);
    chk("b2b_lat", n, 35);
    chk("b2b_res", result, 32'd12);
    @(posedge clk);
    #1 chk("b2b_idle", busy, 0);

    @(negedge clk);
    op = MD_MUL; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    count_done(40, c);
    chk("flush_nodone", c, 0);
    chk("flush_res", result, 32'd12);

    @(negedge clk);
    op = MD_MUL; a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("flush_start_idle", busy, 0);
    count_done(40, c);
    chk("flush_start_nodone", c, 0);

    @(negedge clk);
    op = MD_MUL; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (21) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    @(negedge clk) reset = 1'b0;
    count_done(40, c);
    chk("arst_nodone", c, 0);

    run("after_rst", MD_MULHU, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
